// File: rtl/mvm_pkg.sv
// Shared types for the matrix-vector job scheduler: vector element type,
// vector shape and the scheduler state encoding.
package mvm_pkg;

  localparam int WIDTH = 8;
  localparam int SIZE  = 64;

  typedef logic signed [WIDTH-1:0] vec_t [SIZE];

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    RESP
  } sched_state_t;

endpackage

// File: rtl/mvm_rr_arbiter.sv
// Combinational round-robin arbiter: the first valid request at or above
// the pointer wins, wrapping past NREQ-1 back to 0.
module mvm_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  winner_o
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    grant_o  = '0;
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        winner_o     = idx;
      end
    end
  end

endmodule

// File: rtl/mvm_job_scheduler.sv
// Time-shares one systolic matrix-vector engine between NREQ requesters.
// Define MVM_SCHED_STATS_EN to build the job_count / stall_cycles counters.
module mvm_job_scheduler
  import mvm_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 66,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  vec_t            req_vector [NREQ],
  output logic            eng_rstn,
  output vec_t            eng_in_vector,
  input  vec_t            eng_out_vector,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IDW-1:0]  rsp_id,
  output vec_t            rsp_vector,
  output logic            busy,
  output logic [31:0]     job_count,
  output logic [31:0]     stall_cycles
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  sched_state_t   state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] id_q, id_d;
  vec_t           job_q, job_d;
  vec_t           res_q, res_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win;

  mvm_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .grant_o  (grant),
    .winner_o (win)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    job_d   = job_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = CLEAR;
          job_d   = req_vector[win];
          id_d    = win;
          ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
        end
      end
      CLEAR: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: begin
        if (cnt_q == CW'(LAT - 1)) begin
          state_d = RESP;
          res_d   = eng_out_vector;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      job_q   <= '{default: '0};
      res_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      job_q   <= job_d;
      res_q   <= res_d;
    end
  end

  // The job register only changes on accept, so it doubles as the held engine input.
  assign req_ready     = (state_q == IDLE && !rst) ? grant : '0;
  assign eng_rstn      = !rst && (state_q != CLEAR);
  assign eng_in_vector = job_q;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_id        = id_q;
  assign rsp_vector    = res_q;
  assign busy          = (state_q != IDLE);

`ifdef MVM_SCHED_STATS_EN
  logic [31:0] jobs_q, jobs_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    jobs_d  = jobs_q;
    stall_d = stall_q;
    if (rsp_valid && rsp_ready) jobs_d = jobs_q + 32'd1;
    if (rsp_valid && !rsp_ready && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jobs_q  <= '0;
      stall_q <= '0;
    end else begin
      jobs_q  <= jobs_d;
      stall_q <= stall_d;
    end
  end

  assign job_count    = jobs_q;
  assign stall_cycles = stall_q;
`else
  assign job_count    = '0;
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mvm_job_scheduler.sv
// Bench for mvm_job_scheduler: a stand-in engine, a job-level model checked
// every cycle, and directed scenarios with hand-computed expectations.
module tb_mvm_job_scheduler;
  import mvm_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 66;
  localparam int IDW  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  vec_t            req_vector [NREQ];
  logic            eng_rstn;
  vec_t            eng_in_vector;
  vec_t            eng_out_vector;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [IDW-1:0]  rsp_id;
  vec_t            rsp_vector;
  logic            busy;
  logic [31:0]     job_count;
  logic [31:0]     stall_cycles;

  always #5 clk = ~clk;

  mvm_job_scheduler #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_vector     (req_vector),
    .eng_rstn       (eng_rstn),
    .eng_in_vector  (eng_in_vector),
    .eng_out_vector (eng_out_vector),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_id         (rsp_id),
    .rsp_vector     (rsp_vector),
    .busy           (busy),
    .job_count      (job_count),
    .stall_cycles   (stall_cycles)
  );

  // Stand-in engine: output element i = input element i + cycles since reset release + i.
  logic [7:0] eng_acc = 8'd0;
  always @(posedge clk) eng_acc <= !eng_rstn ? 8'd0 : eng_acc + 8'd1;
  always_comb begin
    for (int i = 0; i < SIZE; i++)
      eng_out_vector[i] = eng_in_vector[i] + $signed(eng_acc) + 8'(i);
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_vec(input string nm, input vec_t a, input vec_t e);
    int bad;
    bad = -1;
    for (int i = 0; i < SIZE; i++)
      if (a[i] !== e[i] && bad < 0) bad = i;
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: element %0d got %0h expected %0h (cyc %0d)", nm, bad, a[bad], e[bad], cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int j = p; j < NREQ; j++) if (v[j]) return j;
    for (int j = 0; j < p; j++) if (v[j]) return j;
    return -1;
  endfunction

  // Job-level model: one job in flight, response due LAT+2 cycles after accept.
  int          m_busy = 0;
  int          m_ptr  = 0;
  int          m_acc  = 0;
  int          m_id   = 0;
  vec_t        m_in   = '{default: '0};
  vec_t        m_exp  = '{default: '0};
  logic [31:0] m_jobs = '0;
  logic [31:0] m_stall = '0;
  int          w;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  <= 0;
      m_ptr   <= 0;
      m_acc   <= 0;
      m_id    <= 0;
      m_in    <= '{default: '0};
      m_exp   <= '{default: '0};
      m_jobs  <= '0;
      m_stall <= '0;
    end else if (m_busy != 0) begin
      if (cyc - m_acc >= LAT + 2) begin
        if (rsp_ready) begin
          m_busy <= 0;
          m_jobs <= m_jobs + 32'd1;
        end else if (m_stall != 32'hFFFF_FFFF) begin
          m_stall <= m_stall + 32'd1;
        end
      end
    end else begin
      w = rr_pick(req_valid, m_ptr);
      if (w >= 0) begin
        m_busy <= 1;
        m_acc  <= cyc;
        m_id   <= w;
        m_in   <= req_vector[w];
        for (int i = 0; i < SIZE; i++)
          m_exp[i] <= req_vector[w][i] + 8'(LAT - 1) + 8'(i);
        m_ptr  <= (w + 1) % NREQ;
      end
    end
  end

  vec_t zv = '{default: '0};

  always @(negedge clk) begin
    int              pk;
    logic [NREQ-1:0] eg;
    logic            ev;
    pk = rr_pick(req_valid, m_ptr);
    eg = (!rst && m_busy == 0 && pk >= 0) ? (NREQ'(1) << pk) : '0;
    ev = !rst && m_busy != 0 && (cyc - m_acc >= LAT + 2);
    chk("req_ready", 64'(req_ready), 64'(eg));
    chk("busy", 64'(busy), 64'(!rst && m_busy != 0));
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    chk("eng_rstn", 64'(eng_rstn), 64'(!rst && !(m_busy != 0 && cyc - m_acc == 1)));
    chk_vec("eng_in_vector", eng_in_vector, m_in);
    if (ev) begin
      chk("rsp_id", 64'(rsp_id), 64'(m_id));
      chk_vec("rsp_vector", rsp_vector, m_exp);
    end
    if (rst) begin
      chk("rst_rsp_id", 64'(rsp_id), 64'(0));
      chk_vec("rst_rsp_vector", rsp_vector, zv);
    end
`ifdef MVM_SCHED_STATS_EN
    chk("job_count", 64'(job_count), 64'(m_jobs));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`else
    chk("job_count", 64'(job_count), 64'(0));
    chk("stall_cycles", 64'(stall_cycles), 64'(0));
`endif
  end

  // Event log of DUT handshakes for the directed checks.
  int acc_ids[$];
  int acc_cyc[$];
  int hs_ids[$];
  int low_cnt = 0;

  always @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREQ; r++)
        if (req_valid[r] && req_ready[r]) begin
          acc_ids.push_back(r);
          acc_cyc.push_back(cyc);
        end
      if (rsp_valid && rsp_ready) hs_ids.push_back(int'(rsp_id));
    end
  end

  always @(negedge clk) if (!rst && !eng_rstn) low_cnt <= low_cnt + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_accept(input string nm);
    int s;
    int k;
    s = acc_ids.size();
    k = 0;
    while (acc_ids.size() == s && k < 200) begin
      tick(1);
      k++;
    end
    chk(nm, 64'(acc_ids.size() > s), 64'(1));
  endtask

  task automatic wait_rsp(input string nm, output int at);
    int k;
    k  = 0;
    at = -1;
    while (k < 300) begin
      @(negedge clk);
      if (rsp_valid) begin
        at = cyc;
        break;
      end
      k++;
    end
    chk(nm, 64'(at >= 0), 64'(1));
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 300) begin
      tick(1);
      k++;
    end
    chk(nm, 64'(busy), 64'(0));
  endtask

  initial begin
    int   at, base, hb, got, n3;
    int   exp_order [6];
    vec_t e0;
    exp_order = '{0, 1, 2, 3, 0, 1};
    for (int r = 0; r < NREQ; r++)
      for (int i = 0; i < SIZE; i++)
        req_vector[r][i] = 8'(r * 37 + i * 5 + 17);

    // Reset state, with every requester pushing to expose an ungated grant.
    req_valid = '1;
    tick(2);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_eng_rstn", 64'(eng_rstn), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_job_count", 64'(job_count), 64'(0));
    chk("rst_stall", 64'(stall_cycles), 64'(0));
    chk_vec("rst_eng_in", eng_in_vector, zv);
    req_valid = '0;
    tick(1);
    rst = 1'b0;
    tick(1);

    // Requester 2 alone, vector all 3.
    for (int i = 0; i < SIZE; i++) req_vector[2][i] = 8'sd3;
    low_cnt   = 0;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t1_grant", 64'(req_ready), 64'(4'b0100));
    wait_accept("t1_accept");
    req_valid = '0;
    wait_rsp("t1_rsp", at);
    chk("t1_latency", 64'(at - acc_cyc[acc_cyc.size() - 1]), 64'(68));
    chk("t1_rsp_id", 64'(rsp_id), 64'(2));
    chk("t1_rsp_elem0", 64'($unsigned(rsp_vector[0])), 64'(68));
    chk("t1_rsp_elem63", 64'($unsigned(rsp_vector[63])), 64'(131));
    chk("t1_eng_rstn_low_cycles", 64'(low_cnt), 64'(1));
    wait_idle("t1_idle");
    for (int i = 0; i < SIZE; i++) req_vector[2][i] = 8'(2 * 37 + i * 5 + 17);

    // All requesters continuously valid.
    apply_reset();
    base      = acc_ids.size();
    req_valid = '1;
    for (int k = 0; k < 600 && acc_ids.size() < base + 6; k++) tick(1);
    req_valid = '0;
    for (int i = 0; i < 6; i++) begin
      got = (base + i < acc_ids.size()) ? acc_ids[base + i] : -1;
      chk("t2_order", 64'(got), 64'(exp_order[i]));
    end
    for (int i = 1; i < 6; i++) begin
      got = (base + i < acc_ids.size()) ? acc_cyc[base + i] - acc_cyc[base + i - 1] : -1;
      chk("t2_spacing", 64'(got), 64'(69));
    end
    wait_idle("t2_idle");

    // Back-pressure on the response for 10 cycles.
    apply_reset();
    for (int i = 0; i < SIZE; i++) e0[i] = req_vector[0][i] + 8'(LAT - 1) + 8'(i);
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    wait_accept("t3_accept");
    req_valid = 4'b0010;
    wait_rsp("t3_rsp", at);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("t3_hold_id", 64'(rsp_id), 64'(0));
      chk_vec("t3_hold_vec", rsp_vector, e0);
      chk("t3_hold_ready", 64'(req_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3_valid_drop", 64'(rsp_valid), 64'(0));
`ifdef MVM_SCHED_STATS_EN
    chk("t3_stall", 64'(stall_cycles), 64'(10));
    chk("t3_jobs", 64'(job_count), 64'(1));
`else
    chk("t3_stall", 64'(stall_cycles), 64'(0));
    chk("t3_jobs", 64'(job_count), 64'(0));
`endif
    wait_accept("t3_next_accept");
    req_valid = '0;
    chk("t3_next_id", 64'(acc_ids[acc_ids.size() - 1]), 64'(1));
    wait_idle("t3_idle");

    // Reset in the middle of RUN (count 30) aborts the job.
    apply_reset();
    req_valid = 4'b0001;
    wait_accept("t4_accept");
    req_valid = '0;
    tick(31);
    rst       = 1'b1;
    req_valid = '1;
    @(negedge clk);
    chk("t4_rst_busy", 64'(busy), 64'(0));
    chk("t4_rst_valid", 64'(rsp_valid), 64'(0));
    chk("t4_rst_eng_rstn", 64'(eng_rstn), 64'(0));
    chk("t4_rst_ready", 64'(req_ready), 64'(0));
    chk_vec("t4_rst_eng_in", eng_in_vector, zv);
    tick(1);
    rst       = 1'b0;
    req_valid = '0;
    hb = hs_ids.size();
    tick(80);
    chk("t4_no_rsp", 64'(hs_ids.size() - hb), 64'(0));
    req_valid = 4'b0001;
    wait_accept("t4_accept2");
    req_valid = '0;
    wait_rsp("t4_rsp2", at);
    chk("t4_rsp_id", 64'(rsp_id), 64'(0));
    wait_idle("t4_idle");

    // Requester 1 re-requests immediately: three back-to-back grants.
    hb        = hs_ids.size();
    req_valid = 4'b0010;
    for (int k = 0; k < 400 && hs_ids.size() < hb + 3; k++) tick(1);
    req_valid = '0;
    chk("t5_count", 64'(hs_ids.size() - hb), 64'(3));
    for (int i = 0; i < 3; i++) begin
      got = (hb + i < hs_ids.size()) ? hs_ids[hb + i] : -1;
      chk("t5_rsp_id", 64'(got), 64'(1));
    end
    wait_idle("t5_idle");

    // Requester 3 withdraws during job 0; requester 1 wins the next contest.
    apply_reset();
    base      = acc_ids.size();
    req_valid = 4'b1001;
    wait_accept("t6_accept0");
    req_valid = 4'b1000;
    tick(10);
    req_valid = 4'b0010;
    wait_accept("t6_accept1");
    req_valid = '0;
    wait_idle("t6_idle");
    got = (base + 1 < acc_ids.size()) ? acc_ids[base + 1] : -1;
    chk("t6_first", 64'(acc_ids[base]), 64'(0));
    chk("t6_second", 64'(got), 64'(1));
    n3 = 0;
    for (int i = base; i < acc_ids.size(); i++) if (acc_ids[i] == 3) n3++;
    chk("t6_req3_never", 64'(n3), 64'(0));

    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
